// File: rtl/sdf_stage_16_if.sv
// Sample/twiddle stream into the SDF stage and the result stream out of it.
// The slave modport is the stage's view; the master modport is the upstream/downstream view.
interface sdf_stage_16_if #(
  parameter int DW = 24
);
  logic          in_valid;
  logic [DW-1:0] din_r;
  logic [DW-1:0] din_i;
  logic [1:0]    state;
  logic [DW-1:0] w_r;
  logic [DW-1:0] w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

// File: rtl/sdf_stage_16.sv
// Radix-2 single-path delay-feedback butterfly stage with an N-deep feedback line.
// The state code from the twiddle ROM selects fill, butterfly or twiddle rotation per sample.
module sdf_stage_16 #(
  parameter int DW   = 24,
  parameter int N    = 16,
  parameter int FRAC = 8
) (
  input logic clk,
  input logic rst_n,
  sdf_stage_16_if.slave bus
);

  localparam int PW = 2 * DW;

  // line_r[0] / line_i[0] is the head (oldest); index N-1 takes the newest push
  logic [DW-1:0] line_r [N];
  logic [DW-1:0] line_i [N];

  logic [DW-1:0] head_r;
  logic [DW-1:0] head_i;
  logic          is_bfly;
  logic          is_twid;
  logic [DW-1:0] sum_r;
  logic [DW-1:0] sum_i;
  logic [DW-1:0] push_r;
  logic [DW-1:0] push_i;
  logic [PW-1:0] hr_x;
  logic [PW-1:0] hi_x;
  logic [PW-1:0] wr_x;
  logic [PW-1:0] wi_x;
  logic [PW-1:0] prod_r;
  logic [PW-1:0] prod_i;
  logic [PW-1:0] shift_r;
  logic [PW-1:0] shift_i;

  assign head_r  = line_r[0];
  assign head_i  = line_i[0];
  assign is_bfly = (bus.state == 2'd1);
  assign is_twid = (bus.state == 2'd2);

  always_comb begin
    sum_r  = bus.din_r + head_r;
    sum_i  = bus.din_i + head_i;
    push_r = bus.din_r;
    push_i = bus.din_i;
    if (is_bfly) begin
      push_r = head_r - bus.din_r;
      push_i = head_i - bus.din_i;
    end
  end

  // Sign-extend to full product width so products and sums wrap at 2*DW bits
  always_comb begin
    hr_x    = {{DW{head_r[DW-1]}}, head_r};
    hi_x    = {{DW{head_i[DW-1]}}, head_i};
    wr_x    = {{DW{bus.w_r[DW-1]}}, bus.w_r};
    wi_x    = {{DW{bus.w_i[DW-1]}}, bus.w_i};
    prod_r  = hr_x * wr_x - hi_x * wi_x;
    prod_i  = hr_x * wi_x + hi_x * wr_x;
    shift_r = $unsigned($signed(prod_r) >>> FRAC);
    shift_i = $unsigned($signed(prod_i) >>> FRAC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        line_r[i] <= '0;
        line_i[i] <= '0;
      end
    end else if (bus.in_valid) begin
      for (int i = 0; i < N - 1; i++) begin
        line_r[i] <= line_r[i+1];
        line_i[i] <= line_i[i+1];
      end
      line_r[N-1] <= push_r;
      line_i[N-1] <= push_i;
    end
  end

  // Data outputs hold unless a butterfly or twiddle sample produces a new result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.dout_r    <= '0;
      bus.dout_i    <= '0;
    end else begin
      bus.out_valid <= bus.in_valid && (is_bfly || is_twid);
      if (bus.in_valid && is_bfly) begin
        bus.dout_r <= sum_r;
        bus.dout_i <= sum_i;
      end else if (bus.in_valid && is_twid) begin
        bus.dout_r <= shift_r[DW-1:0];
        bus.dout_i <= shift_i[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_16.sv
// Directed bench for sdf_stage_16: fill, butterfly, twiddle rotation, wrap, floor, stalls, resets.
module tb_sdf_stage_16;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sdf_stage_16_if #(.DW(24)) bus ();

  sdf_stage_16 #(.DW(24), .N(16), .FRAC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic ev, input int er, input int ei,
                       input logic chk_data);
    logic [23:0] exp_r;
    logic [23:0] exp_i;
    exp_r = er[23:0];
    exp_i = ei[23:0];
    checks++;
    assert (bus.out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid got %0b want %0b", tag, bus.out_valid, ev);
    end
    if (chk_data) begin
      checks++;
      assert (bus.dout_r === exp_r) else begin
        errors++;
        $error("FAIL %s dout_r got %h want %h", tag, bus.dout_r, exp_r);
      end
      checks++;
      assert (bus.dout_i === exp_i) else begin
        errors++;
        $error("FAIL %s dout_i got %h want %h", tag, bus.dout_i, exp_i);
      end
    end
  endtask

  // Present one sample at the falling edge, then land 1 time unit after the capturing edge
  task automatic cycle(input logic v, input int r, input int i, input logic [1:0] st,
                       input int wr, input int wi);
    @(negedge clk);
    bus.in_valid = v;
    bus.din_r    = r[23:0];
    bus.din_i    = i[23:0];
    bus.state    = st;
    bus.w_r      = wr[23:0];
    bus.w_i      = wi[23:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, int'($urandom), int'($urandom), 2'($urandom), int'($urandom), int'($urandom));
  endtask

  int tw_wr [16];
  int tw_wi [16];
  int tw_er [16];
  int tw_ei [16];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    bus.din_r = '0; bus.din_i = '0; bus.state = '0; bus.w_r = '0; bus.w_i = '0;

    for (int k = 0; k < 16; k++) begin
      tw_wr[k] = 256; tw_wi[k] = 0; tw_er[k] = k - 100; tw_ei[k] = 0;
    end
    tw_wr[1] = 0;    tw_wi[1] = -256; tw_er[1] = 0;   tw_ei[1] = 99;
    tw_wr[3] = -256; tw_wi[3] = 0;    tw_er[3] = 97;  tw_ei[3] = 0;
    tw_wr[4] = 181;  tw_wi[4] = -181; tw_er[4] = -68; tw_ei[4] = 67;
    tw_wr[5] = 128;  tw_wi[5] = 128;  tw_er[5] = -48; tw_ei[5] = -48;

    // Reset held with busy random inputs
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, int'($urandom), int'($urandom), 2'($urandom_range(1, 2)),
            int'($urandom), int'($urandom));
      check("reset_hold", 1'b0, 0, 0, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, k, 0, 2'd0, 0, 0);
      check("fill", 1'b0, 0, 0, 1'b1);
    end

    // Butterfly block with a stall in the middle and one across the 1->2 boundary
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 100, 0, 2'd1, int'($urandom), int'($urandom));
      check($sformatf("bfly%0d", k), 1'b1, k + 100, 0, 1'b1);
      if (k == 7 || k == 15) begin
        for (int s = 0; s < 5; s++) begin
          idle();
          check("stall_hold", 1'b0, k + 100, 0, 1'b1);
        end
      end
    end

    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, (k == 0) ? 24'h7FFFFF : 10, 0, 2'd2, tw_wr[k], tw_wi[k]);
      check($sformatf("twid%0d", k), 1'b1, tw_er[k], tw_ei[k], 1'b1);
      if (k == 2) begin
        for (int s = 0; s < 5; s++) begin
          idle();
          check("stall_twid", 1'b0, tw_er[k], tw_ei[k], 1'b1);
        end
      end
    end

    // Second butterfly block: modular wrap at the head, and a difference of 3 for the floor test
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, (k == 0) ? 1 : ((k == 1) ? 7 : 0), 0, 2'd1, 0, 0);
      check($sformatf("bfly2_%0d", k), 1'b1,
            (k == 0) ? 24'h800000 : ((k == 1) ? 17 : 10), 0, 1'b1);
    end

    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 50, 0, 2'd2, (k == 1) ? 181 : 256, (k == 1) ? -181 : 0);
      check($sformatf("twid2_%0d", k), 1'b1,
            (k == 0) ? 24'h7FFFFE : ((k == 1) ? 2 : 10), (k == 1) ? -3 : 0, 1'b1);
    end

    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 5, 0, 2'd1, 0, 0);
      check("bfly3", 1'b1, 55, 0, 1'b1);
    end

    // Asynchronous reset mid-block clears outputs before any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 0, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Heads were cleared, so butterfly output equals the input alone
    cycle(1'b1, 7, 0, 2'd1, 0, 0);
    check("post_reset0", 1'b1, 7, 0, 1'b1);
    cycle(1'b1, 3, 0, 2'd1, 0, 0);
    check("post_reset1", 1'b1, 3, 0, 1'b1);
    cycle(1'b1, 0, 0, 2'd3, 0, 0);
    check("illegal_state", 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
